// File: rtl/fwd_pkg.sv
// Shared definitions for the write-back bypass unit.
// Holds the $0 register index and the history entry layout at the default widths.
package fwd_pkg;

   localparam int HIST_DATA_W = 32;
   localparam int HIST_ADDR_W = 5;

   // MIPS $0 is hardwired to zero and must never be forwarded.
   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic                   valid;
      logic [HIST_ADDR_W-1:0] addr;
      logic [HIST_DATA_W-1:0] data;
   } hist_entry_t;

endpackage

// File: rtl/fwd_port_mux.sv
// Priority select for one read port.
// Candidates are the live write-back, then history entries youngest first, then register-file data.
module fwd_port_mux
   import fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic                    wr_live,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [DEPTH-1:0]        hist_valid,
   input  logic [DEPTH*ADDR_W-1:0] hist_addr,
   input  logic [DEPTH*DATA_W-1:0] hist_data,
   input  logic [ADDR_W-1:0]       rd_addr,
   input  logic [DATA_W-1:0]       rd_data_in,
   output logic [DATA_W-1:0]       rd_data_out,
   output logic                    rd_hit
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   // Scan oldest to youngest so younger matches overwrite older ones; the live write overrides all.
   always_comb begin
      rd_data_out = rd_data_in;
      rd_hit      = 1'b0;
      if (rd_addr != ZERO_ADDR) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist_valid[k] && (hist_addr[k*ADDR_W +: ADDR_W] == rd_addr)) begin
               rd_data_out = hist_data[k*DATA_W +: DATA_W];
               rd_hit      = 1'b1;
            end
         end
         if (wr_live && (wr_addr == rd_addr)) begin
            rd_data_out = wr_data;
            rd_hit      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fwd_history_unit.sv
// Write-back bypass unit: keeps the last DEPTH committed writes and forwards them to NUM_RD read ports
// until the register file's delayed write port has absorbed them.
// Optional feature macro: FWD_STATS_EN adds a saturating 32-bit count of forwarded reads (fwd_hits).
module fwd_history_unit
   import fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     flush,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic [NUM_RD*DATA_W-1:0] rd_data_in,
   output logic [NUM_RD*DATA_W-1:0] rd_data_out,
   output logic [NUM_RD-1:0]        rd_hit,
   output logic [3:0]               hist_count
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]              fwd_hits
`endif
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DEPTH-1:0]        hist_valid_q, hist_valid_d;
   logic [DEPTH*ADDR_W-1:0] hist_addr_q,  hist_addr_d;
   logic [DEPTH*DATA_W-1:0] hist_data_q,  hist_data_d;
   logic [3:0]              hist_count_q, hist_count_d;
   logic                    wr_live;

   assign wr_live    = wr_en && (wr_addr != ZERO_ADDR);
   assign hist_count = hist_count_q;

   // Shift history one slot older, load the new write into slot 0, drop shifted entries on flush.
   always_comb begin
      hist_valid_d = '0;
      hist_addr_d  = hist_addr_q;
      hist_data_d  = hist_data_q;
      hist_valid_d[0]           = wr_live;
      hist_addr_d[ADDR_W-1:0]   = wr_addr;
      hist_data_d[DATA_W-1:0]   = wr_data;
      for (int k = 1; k < DEPTH; k++) begin
         hist_valid_d[k]                 = hist_valid_q[k-1] && !flush;
         hist_addr_d[k*ADDR_W +: ADDR_W] = hist_addr_q[(k-1)*ADDR_W +: ADDR_W];
         hist_data_d[k*DATA_W +: DATA_W] = hist_data_q[(k-1)*DATA_W +: DATA_W];
      end
      hist_count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         hist_count_d = hist_count_d + {3'b000, hist_valid_d[k]};
      end
   end

   // Valid bits and occupancy are the only state that must be cleared by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_valid_q <= '0;
         hist_count_q <= '0;
      end else begin
         hist_valid_q <= hist_valid_d;
         hist_count_q <= hist_count_d;
      end
   end

   // Address and data payloads are qualified by the valid bits, so they run without reset.
   always_ff @(posedge clk) begin
      hist_addr_q <= hist_addr_d;
      hist_data_q <= hist_data_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      fwd_port_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_mux (
         .wr_live     (wr_live),
         .wr_addr     (wr_addr),
         .wr_data     (wr_data),
         .hist_valid  (hist_valid_q),
         .hist_addr   (hist_addr_q),
         .hist_data   (hist_data_q),
         .rd_addr     (rd_addr[i*ADDR_W +: ADDR_W]),
         .rd_data_in  (rd_data_in[i*DATA_W +: DATA_W]),
         .rd_data_out (rd_data_out[i*DATA_W +: DATA_W]),
         .rd_hit      (rd_hit[i])
      );
   end

`ifdef FWD_STATS_EN
   logic [31:0] fwd_hits_q, fwd_hits_d;
   logic [32:0] hits_sum;

   assign fwd_hits = fwd_hits_q;

   // Add this cycle's forwarded ports, clamping at all-ones instead of wrapping.
   always_comb begin
      hits_sum = {1'b0, fwd_hits_q};
      for (int i = 0; i < NUM_RD; i++) begin
         hits_sum = hits_sum + {32'd0, rd_hit[i]};
      end
      fwd_hits_d = hits_sum[32] ? '1 : hits_sum[31:0];
   end

   // Statistics survive flushes; only reset clears them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_hits_q <= '0;
      end else begin
         fwd_hits_q <= fwd_hits_d;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_history_unit.sv
// Self-checking bench for fwd_history_unit at default parameters (DEPTH=2, NUM_RD=2).
// Each vector holds one cycle of stimulus plus the outputs expected during that cycle.
module tb_fwd_history_unit;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;
   localparam int NUM_RD = 2;

   typedef struct packed {
      logic        rstN;
      logic        wrEn;
      logic [4:0]  wrAddr;
      logic [31:0] wrData;
      logic        flush;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] in0;
      logic [31:0] in1;
      logic [31:0] expOut0;
      logic [31:0] expOut1;
      logic [1:0]  expHit;
      logic [3:0]  expCount;
   } vector_t;

   logic                     clk;
   logic                     reset_n;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     flush;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data_in;
   logic [NUM_RD*DATA_W-1:0] rd_data_out;
   logic [NUM_RD-1:0]        rd_hit;
   logic [3:0]               hist_count;
`ifdef FWD_STATS_EN
   logic [31:0]              fwd_hits;
   logic [31:0]              expStats;
`endif

   vector_t expQueue[$];
   vector_t table0[13];
   int      checksTotal;
   int      checksPassed;
   int      rowId;

   fwd_history_unit #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .NUM_RD (NUM_RD)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .flush       (flush),
      .rd_addr     (rd_addr),
      .rd_data_in  (rd_data_in),
      .rd_data_out (rd_data_out),
      .rd_hit      (rd_hit),
      .hist_count  (hist_count)
`ifdef FWD_STATS_EN
      ,
      .fwd_hits    (fwd_hits)
`endif
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vector_t mkVec(input logic rstN, input logic wrEn, input logic [4:0] wrAddr,
                                     input logic [31:0] wrData, input logic fl,
                                     input logic [4:0] ra0, input logic [4:0] ra1,
                                     input logic [31:0] in0, input logic [31:0] in1,
                                     input logic [31:0] eo0, input logic [31:0] eo1,
                                     input logic [1:0] eh, input logic [3:0] ec);
      vector_t v;
      v.rstN = rstN;  v.wrEn = wrEn;  v.wrAddr = wrAddr;  v.wrData = wrData;  v.flush = fl;
      v.ra0 = ra0;    v.ra1 = ra1;    v.in0 = in0;        v.in1 = in1;
      v.expOut0 = eo0; v.expOut1 = eo1; v.expHit = eh;    v.expCount = ec;
      return v;
   endfunction

   task automatic compare(input string name, input logic [31:0] got, input logic [31:0] req);
      checksTotal++;
      if (got === req) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s (row %0d): got %h, required %h", name, rowId, got, req);
      end
   endtask

   task automatic checkOutput();
      vector_t e;
      if (expQueue.size() == 0) begin
         checksTotal++;
         $display("[TB] FAIL scoreboard (row %0d): got empty queue, required an entry", rowId);
      end else begin
         e = expQueue.pop_front();
         compare("rd_data_out0", rd_data_out[31:0],  e.expOut0);
         compare("rd_data_out1", rd_data_out[63:32], e.expOut1);
         compare("rd_hit",       {30'd0, rd_hit},    {30'd0, e.expHit});
         compare("hist_count",   {28'd0, hist_count}, {28'd0, e.expCount});
`ifdef FWD_STATS_EN
         if (!e.rstN) expStats = '0;
         compare("fwd_hits", fwd_hits, expStats);
         if (e.rstN) expStats = expStats + {31'd0, e.expHit[0]} + {31'd0, e.expHit[1]};
`endif
      end
   endtask

   // Drive one cycle mid-period, queue its expectations, then sample well before the next rising edge.
   task automatic applyStimulus(input vector_t v);
      @(negedge clk);
      reset_n    = v.rstN;
      wr_en      = v.wrEn;
      wr_addr    = v.wrAddr;
      wr_data    = v.wrData;
      flush      = v.flush;
      rd_addr    = {v.ra1, v.ra0};
      rd_data_in = {v.in1, v.in0};
      expQueue.push_back(v);
      #2;
      checkOutput();
      rowId++;
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      rowId        = 0;
`ifdef FWD_STATS_EN
      expStats     = '0;
`endif
      reset_n    = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      flush      = 1'b0;
      rd_addr    = '0;
      rd_data_in = '0;

      //                 rst wr addr data      fl  ra0 ra1 in0          in1          out0         out1         hit    cnt
      table0[0]  = mkVec(0, 0, 0,  32'h0,     0,  5,  6,  32'h11,      32'h22,      32'h11,      32'h22,      2'b00, 0);
      table0[1]  = mkVec(1, 1, 5,  32'hAAAA,  0,  5,  6,  32'h11,      32'h22,      32'hAAAA,    32'h22,      2'b01, 0);
      table0[2]  = mkVec(1, 0, 0,  32'h0,     0,  6,  5,  32'h33,      32'h44,      32'h33,      32'hAAAA,    2'b10, 1);
      table0[3]  = mkVec(1, 1, 7,  32'h1234,  0,  5,  5,  32'h55,      32'h66,      32'hAAAA,    32'hAAAA,    2'b11, 1);
      table0[4]  = mkVec(1, 0, 0,  32'h0,     0,  7,  0,  32'h77,      32'h88,      32'h1234,    32'h88,      2'b01, 1);
      table0[5]  = mkVec(1, 0, 0,  32'h0,     0,  7,  7,  32'h99,      32'h9A,      32'h1234,    32'h1234,    2'b11, 1);
      table0[6]  = mkVec(1, 0, 0,  32'h0,     0,  7,  5,  32'hB0,      32'hB1,      32'hB0,      32'hB1,      2'b00, 0);
      table0[7]  = mkVec(1, 1, 3,  32'h1,     0,  3,  4,  32'hC0,      32'hC1,      32'h1,       32'hC1,      2'b01, 0);
      table0[8]  = mkVec(1, 1, 3,  32'h2,     0,  3,  3,  32'hC2,      32'hC3,      32'h2,       32'h2,       2'b11, 1);
      table0[9]  = mkVec(1, 0, 0,  32'h0,     0,  3,  3,  32'hD0,      32'hD1,      32'h2,       32'h2,       2'b11, 2);
      table0[10] = mkVec(1, 1, 3,  32'h3,     0,  3,  8,  32'hE0,      32'hE1,      32'h3,       32'hE1,      2'b01, 1);
      table0[11] = mkVec(1, 1, 0,  32'hFFFF,  0,  0,  3,  32'hF0,      32'hF1,      32'hF0,      32'h3,       2'b10, 1);
      table0[12] = mkVec(1, 0, 0,  32'h0,     0,  0,  3,  32'h100,     32'h101,     32'h100,     32'h3,       2'b10, 1);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(table0[i]);
      end

      $display("[TB] flush sequence");
      applyStimulus(mkVec(1, 1, 10, 32'hA10, 0, 1,  2,  32'h200, 32'h201, 32'h200, 32'h201, 2'b00, 0));
      applyStimulus(mkVec(1, 1, 11, 32'hB11, 0, 10, 11, 32'h300, 32'h301, 32'hA10, 32'hB11, 2'b11, 1));
      applyStimulus(mkVec(1, 1, 9,  32'h55,  1, 10, 11, 32'h400, 32'h401, 32'hA10, 32'hB11, 2'b11, 2));
      applyStimulus(mkVec(1, 0, 0,  32'h0,   0, 9,  11, 32'h500, 32'h501, 32'h55,  32'h501, 2'b01, 1));
      applyStimulus(mkVec(1, 0, 0,  32'h0,   0, 10, 9,  32'h600, 32'h601, 32'h600, 32'h55,  2'b10, 1));

      $display("[TB] asynchronous reset sequence");
      applyStimulus(mkVec(1, 1, 12, 32'hC12, 0, 1,  2,  32'h650, 32'h651, 32'h650, 32'h651, 2'b00, 0));
      applyStimulus(mkVec(1, 1, 13, 32'hD13, 0, 12, 13, 32'h700, 32'h701, 32'hC12, 32'hD13, 2'b11, 1));
      applyStimulus(mkVec(0, 1, 13, 32'hE13, 0, 12, 13, 32'h800, 32'h801, 32'h800, 32'hE13, 2'b10, 0));
      applyStimulus(mkVec(1, 0, 0,  32'h0,   0, 12, 13, 32'h900, 32'h901, 32'h900, 32'h901, 2'b00, 0));

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
